// File: rtl/ifetch_pfq_pkg.sv
// Shared constants and helpers for the ifetch_pfq prefetch fetch stage.
// Holds the default widths and reset PC used across the fetch slice.
package ifetch_pfq_pkg;

  localparam int unsigned NOOBS_ADDR_W   = 12;
  localparam int unsigned NOOBS_INST_W   = 8;
  localparam logic [31:0] NOOBS_RESET_PC = 32'h0000_0000;

  // Stale responses can pile up across back-to-back redirects, so this is wider than the queue.
  localparam int unsigned DROP_W = 16;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/ifetch_pfq_if.sv
// Fetch-stage bundle: control inputs, instruction-memory req/gnt/rvalid and the decode handshake.
// master = fetch unit, slave = its surroundings (ctrl, imem, decode).
interface ifetch_pfq_if
  import ifetch_pfq_pkg::*;
#(
  parameter int unsigned ADDR_W = NOOBS_ADDR_W,
  parameter int unsigned INST_W = NOOBS_INST_W
);
  logic              ifetch_en;
  logic              branch;
  logic [ADDR_W-1:0] tgt_addr;
  logic              imem_req;
  logic [ADDR_W-1:0] imem_addr;
  logic              imem_gnt;
  logic              imem_rvalid;
  logic [INST_W-1:0] imem_rdata;
  logic              inst_valid;
  logic              inst_ready;
  logic [INST_W-1:0] inst_o;
  logic [ADDR_W-1:0] inst_pc;
  logic [ADDR_W-1:0] next_addr;

  modport master (
    input  ifetch_en, branch, tgt_addr, imem_gnt, imem_rvalid, imem_rdata, inst_ready,
    output imem_req, imem_addr, inst_valid, inst_o, inst_pc, next_addr
  );

  modport slave (
    output ifetch_en, branch, tgt_addr, imem_gnt, imem_rvalid, imem_rdata, inst_ready,
    input  imem_req, imem_addr, inst_valid, inst_o, inst_pc, next_addr
  );
endinterface

// File: rtl/ifetch_pfq_fifo.sv
// Synchronous prefetch FIFO holding {inst, pc} entries, with flush.
// Head data reads as zero while empty so decode never sees stale storage.
module ifetch_pfq_fifo #(
  parameter int unsigned WIDTH = 20,
  parameter int unsigned DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   i_push,
  input  logic                   i_pop,
  input  logic                   i_flush,
  input  logic [WIDTH-1:0]       i_data,
  output logic [WIDTH-1:0]       o_data,
  output logic [$clog2(DEPTH):0] o_count,
  output logic                   o_full,
  output logic                   o_empty
);
  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = PtrW + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PtrW-1:0]  r_wr_ptr;
  logic [PtrW-1:0]  r_rd_ptr;
  logic [CntW-1:0]  r_count;
  logic             w_do_pop;

  assign o_empty  = (r_count == '0);
  assign o_full   = (r_count == CntW'(DEPTH));
  assign o_count  = r_count;
  assign w_do_pop = i_pop & ~o_empty;
  assign o_data   = o_empty ? '0 : r_mem[r_rd_ptr];

  always_ff @(posedge clk) begin
    if (reset || i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (i_push) r_wr_ptr <= r_wr_ptr + PtrW'(1);
      if (w_do_pop) r_rd_ptr <= r_rd_ptr + PtrW'(1);
      r_count <= r_count + CntW'(i_push) - CntW'(w_do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset && !i_flush && i_push) r_mem[r_wr_ptr] <= i_data;
  end

endmodule

// File: rtl/ifetch_pfq.sv
// PC generator with credit-limited pipelined imem reads feeding a DEPTH-entry prefetch queue.
// Optional IFETCH_PERF_CNT_EN adds saturating flush / empty-cycle performance counters.
module ifetch_pfq
  import ifetch_pfq_pkg::*;
#(
  parameter int unsigned       ADDR_W   = NOOBS_ADDR_W,
  parameter int unsigned       INST_W   = NOOBS_INST_W,
  parameter int unsigned       DEPTH    = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(NOOBS_RESET_PC)
) (
  input  logic         clk,
  input  logic         reset,
  ifetch_pfq_if.master bus
`ifdef IFETCH_PERF_CNT_EN
  ,
  output logic [15:0]  perf_flush_cnt,
  output logic [15:0]  perf_empty_cnt
`endif
);
  localparam int unsigned CntW  = $clog2(DEPTH) + 1;
  localparam int unsigned EntW  = INST_W + ADDR_W;

  logic [ADDR_W-1:0] r_pc;
  logic [ADDR_W-1:0] r_rsp_pc;
  logic [CntW-1:0]   r_outstanding;
  logic [DROP_W-1:0] r_drop;

  logic [CntW-1:0]   w_count;
  logic [CntW:0]     w_inflight;
  logic              w_credit_ok;
  logic              w_req;
  logic              w_accept;
  logic              w_rsp;
  logic              w_drop_now;
  logic              w_push;
  logic              w_pop;
  logic              w_full;
  logic              w_empty;
  logic              w_valid;
  logic [EntW-1:0]   w_head;
  logic [ADDR_W-1:0] w_inst_pc;

  assign w_inflight  = {1'b0, w_count} + {1'b0, r_outstanding};
  assign w_credit_ok = w_inflight < (CntW + 1)'(DEPTH);
  assign w_req       = bus.ifetch_en & ~bus.branch & ~reset & w_credit_ok;
  assign w_accept    = w_req & bus.imem_gnt;

  // Responses in a branch cycle are folded into the drop count, never pushed.
  assign w_rsp      = bus.imem_rvalid & ~bus.branch & ~reset;
  assign w_drop_now = w_rsp & (r_drop != '0);
  assign w_push     = w_rsp & (r_drop == '0);
  assign w_valid    = ~w_empty;
  assign w_pop      = w_valid & bus.inst_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_pc          <= RESET_PC;
      r_rsp_pc      <= RESET_PC;
      r_outstanding <= '0;
      r_drop        <= '0;
    end else if (bus.branch) begin
      r_pc          <= bus.tgt_addr;
      r_rsp_pc      <= bus.tgt_addr;
      r_outstanding <= '0;
      r_drop        <= r_drop + DROP_W'(r_outstanding) - DROP_W'(bus.imem_rvalid);
    end else begin
      if (w_accept) r_pc <= r_pc + ADDR_W'(1);
      if (w_push) r_rsp_pc <= r_rsp_pc + ADDR_W'(1);
      if (w_drop_now) r_drop <= r_drop - DROP_W'(1);
      r_outstanding <= r_outstanding + CntW'(w_accept) - CntW'(w_push);
    end
  end

  ifetch_pfq_fifo #(
    .WIDTH (EntW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_flush (bus.branch),
    .i_data  ({bus.imem_rdata, r_rsp_pc}),
    .o_data  (w_head),
    .o_count (w_count),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  assign w_inst_pc      = w_head[ADDR_W-1:0];
  assign bus.imem_req   = w_req;
  assign bus.imem_addr  = r_pc;
  assign bus.inst_valid = w_valid;
  assign bus.inst_o     = w_head[ADDR_W +: INST_W];
  assign bus.inst_pc    = w_inst_pc;
  assign bus.next_addr  = w_inst_pc + ADDR_W'(1);

  // Credit accounting keeps count + outstanding <= DEPTH, so a push can never hit a full queue.
  a_no_overflow: assert property (@(posedge clk) disable iff (reset) w_push |-> (!w_full || w_pop));

`ifdef IFETCH_PERF_CNT_EN
  logic [15:0] r_flush_cnt;
  logic [15:0] r_empty_cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_flush_cnt <= '0;
      r_empty_cnt <= '0;
    end else begin
      if (bus.branch) r_flush_cnt <= sat_inc16(r_flush_cnt);
      if (!w_valid) r_empty_cnt <= sat_inc16(r_empty_cnt);
    end
  end

  assign perf_flush_cnt = r_flush_cnt;
  assign perf_empty_cnt = r_empty_cnt;
`endif

endmodule
